dht_sensor_controller: RTL and testbench



---
 rtl/dht_pkg.sv | 39 +++
 rtl/dht_tick_gen.sv | 31 +++
 rtl/dht_sensor_controller.sv | 217 +++++++++++++++++++++
 tb/tb_dht_sensor_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared types and constants for the DHT sensor controller
// Purpose: FSM state enum, error codes, mode constants, frame size and
//          the checksum helper used by dht_sensor_controller.
// Ports:   none (package).
package dht_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_RELEASE   = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_BIT_LOW   = 4'd5,
    S_BIT_HIGH  = 4'd6,
    S_CHECK     = 4'd7,
    S_FAIL      = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_NORESP = 2'd1;
  localparam logic [1:0] ERR_BIT_TO = 2'd2;
  localparam logic [1:0] ERR_CSUM   = 2'd3;

  localparam logic MODE_DHT11 = 1'b0;
  localparam logic MODE_DHT22 = 1'b1;

  localparam int FRAME_BITS = 40;

  // Sum of the four payload bytes, kept 10 bits wide so no carry is lost.
  function automatic logic [9:0] frame_sum(input logic [FRAME_BITS-1:0] f);
    return {2'b00, f[39:32]} + {2'b00, f[31:24]} + {2'b00, f[23:16]} + {2'b00, f[15:8]};
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dht_tick_gen.sv
// rtl/dht_tick_gen.sv - 1 us tick prescaler
// Purpose: divides clk by CLK_HZ/1e6 and emits a one-cycle tick per microsecond.
// Ports:   clk, rst (sync, active-high), clear (sync restart of the prescaler),
//          tick (one-cycle pulse every microsecond).
module dht_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht_sensor_controller.sv
// rtl/dht_sensor_controller.sv - single-wire DHT11/DHT22 read controller
// Purpose: issues the host start pulse, times the sensor response and the
//          40 data bits, verifies the checksum and publishes the result.
//          Optional feature macro: DHT_AUTO_POLL_EN (periodic self-start).
// Ports:   clk, rst (sync, active-high), start (one-cycle read request),
//          mode (0 DHT11 / 1 DHT22), dhtio (open-drain sensor line),
//          humidity, temperature (last good frame), dht_done (end pulse),
//          dht_valid (last read passed), busy, err_code, debug (state).
module dht_sensor_controller
  import dht_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int START_LOW_US_11 = 19_000,
  parameter int START_LOW_US_22 = 1_100,
  parameter int RELEASE_US      = 30,
  parameter int BIT_THRESH_US   = 50,
  parameter int TIMEOUT_US      = 200,
  parameter int POLL_PERIOD_MS  = 2_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  inout  wire         dhtio,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        dht_done,
  output logic        dht_valid,
  output logic        busy,
  output logic [1:0]  err_code,
  output logic [3:0]  debug
);

  if ((CLK_HZ % 1_000_000) != 0 || CLK_HZ < 1_000_000 || POLL_PERIOD_MS < 1) begin : g_bad_params
    $error("dht_sensor_controller: CLK_HZ must be a multiple of 1 MHz and POLL_PERIOD_MS >= 1");
  end

  localparam int US_MAX = max_int(max_int(START_LOW_US_11, START_LOW_US_22),
                                  max_int(TIMEOUT_US, RELEASE_US));
  localparam int US_W   = $clog2(US_MAX + 1);

  state_t                  state;
  logic [US_W-1:0]         us_cnt;
  logic [5:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    mode_q;
  logic [1:0]              err_pend;
  logic                    drive_low;
  logic [1:0]              sync;
  logic                    line_q;
  logic                    rise, fall, tick, accept, poll_req, timeout;
  logic [US_W-1:0]         low_us;
  logic [9:0]              sum;

  // Open-drain: the line is only ever pulled low or released.
  assign dhtio = drive_low ? 1'b0 : 1'bz;

  // Synchronizer resets high so the pulled-up idle line gives no false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= 2'b11;
      line_q <= 1'b1;
    end else begin
      sync   <= {sync[0], dhtio};
      line_q <= sync[1];
    end
  end

  assign rise    = sync[1] & ~line_q;
  assign fall    = ~sync[1] & line_q;
  assign timeout = (us_cnt == US_W'(TIMEOUT_US));
  assign low_us  = (mode_q == MODE_DHT22) ? US_W'(START_LOW_US_22) : US_W'(START_LOW_US_11);
  assign sum     = frame_sum(shreg);

  // busy is still high in the dht_done cycle, which blocks a same-cycle start.
  assign accept = (state == S_IDLE) && !busy && (start || poll_req);

  dht_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

`ifdef DHT_AUTO_POLL_EN
  localparam int MS_W = $clog2(POLL_PERIOD_MS + 1);

  logic [9:0]      poll_us;
  logic [MS_W-1:0] poll_ms;
  logic            poll_armed;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      poll_armed <= 1'b0;
      poll_us    <= '0;
      poll_ms    <= '0;
    end else if (dht_done) begin
      poll_armed <= 1'b1;
      poll_us    <= '0;
      poll_ms    <= '0;
    end else if (poll_armed && tick && poll_ms != MS_W'(POLL_PERIOD_MS)) begin
      if (poll_us == 10'd999) begin
        poll_us <= '0;
        poll_ms <= poll_ms + 1'b1;
      end else begin
        poll_us <= poll_us + 1'b1;
      end
    end
  end

  assign poll_req = poll_armed && (poll_ms == MS_W'(POLL_PERIOD_MS));
`else
  assign poll_req = 1'b0;
`endif

  // Every state change also clears us_cnt (the later assignment wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      us_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      mode_q      <= MODE_DHT11;
      err_pend    <= ERR_NONE;
      humidity    <= '0;
      temperature <= '0;
      dht_done    <= 1'b0;
      dht_valid   <= 1'b0;
      err_code    <= ERR_NONE;
      busy        <= 1'b0;
      drive_low   <= 1'b0;
      debug       <= S_IDLE;
    end else begin
      dht_done  <= 1'b0;
      busy      <= (state != S_IDLE);
      drive_low <= (state == S_START_LOW);
      debug     <= state;
      if (tick) us_cnt <= us_cnt + 1'b1;

      unique case (state)
        S_IDLE: if (accept) begin
          state    <= S_START_LOW;
          us_cnt   <= '0;
          mode_q   <= mode;
          bit_cnt  <= '0;
          err_pend <= ERR_NONE;
        end
        S_START_LOW: if (us_cnt == low_us) begin
          state  <= S_RELEASE;
          us_cnt <= '0;
        end
        S_RELEASE: if (us_cnt == US_W'(RELEASE_US)) begin
          state  <= S_RESP_LOW;
          us_cnt <= '0;
        end
        S_RESP_LOW, S_RESP_HIGH: begin
          if ((state == S_RESP_LOW) ? rise : fall) begin
            state  <= (state == S_RESP_LOW) ? S_RESP_HIGH : S_BIT_LOW;
            us_cnt <= '0;
          end else if (timeout) begin
            err_pend <= ERR_NORESP;
            state    <= S_FAIL;
            us_cnt   <= '0;
          end
        end
        S_BIT_LOW: begin
          if (rise) begin
            state  <= S_BIT_HIGH;
            us_cnt <= '0;
          end else if (timeout) begin
            err_pend <= ERR_BIT_TO;
            state    <= S_FAIL;
            us_cnt   <= '0;
          end
        end
        S_BIT_HIGH: begin
          if (fall) begin
            shreg   <= {shreg[FRAME_BITS-2:0], (us_cnt > US_W'(BIT_THRESH_US))};
            bit_cnt <= bit_cnt + 1'b1;
            state   <= (bit_cnt == 6'(FRAME_BITS - 1)) ? S_CHECK : S_BIT_LOW;
            us_cnt  <= '0;
          end else if (timeout) begin
            err_pend <= ERR_BIT_TO;
            state    <= S_FAIL;
            us_cnt   <= '0;
          end
        end
        S_CHECK: begin
          us_cnt <= '0;
          if ((sum & 10'h0FF) == {2'b00, shreg[7:0]}) begin
            state <= S_DONE;
          end else begin
            err_pend <= ERR_CSUM;
            state    <= S_FAIL;
          end
        end
        S_FAIL: begin
          state  <= S_DONE;
          us_cnt <= '0;
        end
        S_DONE: begin
          dht_done  <= 1'b1;
          err_code  <= err_pend;
          dht_valid <= (err_pend == ERR_NONE);
          if (err_pend == ERR_NONE) begin
            humidity    <= shreg[39:24];
            temperature <= shreg[23:8];
          end
          state  <= S_IDLE;
          us_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_sensor_controller.sv
// tb/tb_dht_sensor_controller.sv - randomized self-checking bench for dht_sensor_controller
module tb_dht_sensor_controller;
  import dht_pkg::*;

  localparam int CLK_HZ = 2_000_000;
  localparam int CPU    = CLK_HZ / 1_000_000;
  localparam int LOW11  = 800;
  localparam int LOW22  = 400;
  localparam int REL    = 30;
  localparam int TO     = 200;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, sensor_low = 1'b0;
  wire  dhtio;
  logic [15:0] humidity, temperature;
  logic        dht_done, dht_valid, busy;
  logic [1:0]  err_code;
  logic [3:0]  debug;

  int total = 0, bad = 0, done_cnt = 0;
  logic [15:0] exp_hum = 16'h0, exp_temp = 16'h0;

  pullup (dhtio);
  assign dhtio = sensor_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  dht_sensor_controller #(
    .CLK_HZ(CLK_HZ), .START_LOW_US_11(LOW11), .START_LOW_US_22(LOW22),
    .RELEASE_US(REL), .BIT_THRESH_US(50), .TIMEOUT_US(TO), .POLL_PERIOD_MS(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dhtio(dhtio),
    .humidity(humidity), .temperature(temperature), .dht_done(dht_done),
    .dht_valid(dht_valid), .busy(busy), .err_code(err_code), .debug(debug)
  );

  always @(negedge clk) if (dht_done === 1'b1) done_cnt++;

  // Reference: outcome of a read from the frame content and sensor behaviour.
  function automatic int model_err(input logic [39:0] f, input bit respond, input int stall);
    int s;
    if (!respond) return 1;
    if (stall < 40) return 2;
    s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    return (s == int'(f[7:0])) ? 0 : 3;
  endfunction

  task automatic us_wait(input int n);
    repeat (n * CPU) @(negedge clk);
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk); mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Sensor behaviour: measure host low time, then answer with the frame.
  task automatic sensor_run(input logic [39:0] f, input bit respond, input int stall, output int low_cyc);
    int n;
    n = 0; low_cyc = 0;
    while (dhtio !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (dhtio !== 1'b0) return;
    while (dhtio === 1'b0 && low_cyc < 4000) begin @(negedge clk); low_cyc++; end
    if (!respond) return;
    us_wait(20); sensor_low = 1'b1; us_wait(80); sensor_low = 1'b0; us_wait(80);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1; us_wait(40); sensor_low = 1'b0;
      if (i == stall) begin us_wait(400); return; end
      us_wait(f[39-i] ? 70 : 26);
    end
    sensor_low = 1'b1; us_wait(40); sensor_low = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke, output int cyc, output bit seen);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk); cyc++;
      if (dht_done === 1'b1) seen = 1'b1;
    end
    if (seen && poke) begin start = 1'b1; @(negedge clk); start = 1'b0; end
  endtask

  task automatic transact(input logic m, input logic [39:0] f, input int stall, input bit pokes,
                          output int low_cyc, output int dones);
    int c0, cyc;
    bit seen;
    c0 = done_cnt;
    pulse_start(m);
    fork
      sensor_run(f, 1'b1, stall, low_cyc);
      wait_done(30000, pokes, cyc, seen);
      if (pokes) begin
        us_wait(50); pulse_start(1'b1); us_wait(300); pulse_start(1'b1); us_wait(2000); pulse_start(1'b1);
      end
    join
    us_wait(5);
    dones = done_cnt - c0;
  endtask

  // Runs one responding read and compares everything against the model.
  task automatic test_frame(input string name, input logic m, input logic [39:0] f, input int stall);
    int low_cyc, dones, e, exp_low;
    e = model_err(f, 1'b1, stall);
    if (e == 0) begin exp_hum = f[39:24]; exp_temp = f[23:8]; end
    exp_low = (m ? LOW22 : LOW11) * CPU;
    transact(m, f, stall, 1'b0, low_cyc, dones);
    total++;
    if (low_cyc < exp_low - 4 || low_cyc > exp_low + 4) begin
      bad++; $display("FAIL %s_start_low: got %0d cycles, required %0d +-4", name, low_cyc, exp_low);
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL %s_done_count: got %0d, required 1", name, dones); end
    total++;
    if ({err_code, dht_valid, humidity, temperature} !== {2'(e), (e == 0), exp_hum, exp_temp}) begin
      bad++;
      $display("FAIL %s_result: got err=%0d valid=%b hum=%h temp=%h, required err=%0d valid=%b hum=%h temp=%h",
               name, err_code, dht_valid, humidity, temperature, e, (e == 0), exp_hum, exp_temp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({humidity, temperature, dht_done, dht_valid, busy, err_code} !== 37'h0) begin
      bad++; $display("FAIL reset_outputs: got hum=%h temp=%h done=%b valid=%b busy=%b err=%0d, required all 0",
                      humidity, temperature, dht_done, dht_valid, busy, err_code);
    end
    total++;
    if (debug !== 4'(S_IDLE)) begin bad++; $display("FAIL reset_debug: got %0d, required %0d", debug, S_IDLE); end
    total++;
    if (dhtio !== 1'b1) begin bad++; $display("FAIL reset_line: got %b, required released (1)", dhtio); end
  endtask

  task automatic test_dht11();
    test_frame("dht11", 1'b0, {8'h37, 8'h00, 8'h1A, 8'h05, 8'h56}, 99);
  endtask

  task automatic test_dht22();
    test_frame("dht22", 1'b1, {8'h02, 8'h8C, 8'h01, 8'h5F, 8'hEE}, 99);
  endtask

  task automatic test_no_response();
    int low_cyc, cyc, c0, exp_cyc;
    bit seen;
    c0 = done_cnt;
    exp_cyc = (REL + TO) * CPU;
    pulse_start(1'b0);
    sensor_run(40'h0, 1'b0, 99, low_cyc);
    wait_done(2000, 1'b0, cyc, seen);
    us_wait(5);
    total++;
    if (!seen || cyc < exp_cyc - 8 || cyc > exp_cyc + 8) begin
      bad++; $display("FAIL noresp_latency: seen=%b after %0d cycles, required %0d +-8", seen, cyc, exp_cyc);
    end
    total++;
    if ({err_code, dht_valid, humidity, temperature} !== {ERR_NORESP, 1'b0, exp_hum, exp_temp}) begin
      bad++; $display("FAIL noresp_result: got err=%0d valid=%b hum=%h temp=%h, required err=1 valid=0 hum=%h temp=%h",
                      err_code, dht_valid, humidity, temperature, exp_hum, exp_temp);
    end
    total++;
    if (done_cnt - c0 !== 1) begin bad++; $display("FAIL noresp_done_count: got %0d, required 1", done_cnt - c0); end
  endtask

  task automatic test_checksum();
    test_frame("csum", 1'b0, {8'h37, 8'h00, 8'h1A, 8'h05, 8'h57}, 99);
  endtask

  task automatic test_stall();
    test_frame("stall", 1'b0, {8'h37, 8'h00, 8'h1A, 8'h05, 8'h56}, 20);
  endtask

  task automatic test_busy_start();
    logic [39:0] f;
    int low_cyc, dones, e;
    bit restarted;
    f = {8'h41, 8'h10, 8'h22, 8'h03, 8'h76};
    e = model_err(f, 1'b1, 99);
    if (e == 0) begin exp_hum = f[39:24]; exp_temp = f[23:8]; end
    transact(1'b0, f, 99, 1'b1, low_cyc, dones);
    restarted = 1'b0;
    repeat (100) begin @(negedge clk); if (busy !== 1'b0 || dhtio !== 1'b1) restarted = 1'b1; end
    total++;
    if (low_cyc < LOW11 * CPU - 4 || low_cyc > LOW11 * CPU + 4) begin
      bad++; $display("FAIL busy_start_low: got %0d cycles, required %0d +-4", low_cyc, LOW11 * CPU);
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL busy_done_count: got %0d, required 1", dones); end
    total++;
    if (restarted) begin bad++; $display("FAIL done_cycle_start: got a new read, required start ignored"); end
    total++;
    if ({err_code, dht_valid, humidity, temperature} !== {2'(e), (e == 0), exp_hum, exp_temp}) begin
      bad++; $display("FAIL busy_result: got err=%0d valid=%b hum=%h temp=%h, required err=%0d hum=%h temp=%h",
                      err_code, dht_valid, humidity, temperature, e, exp_hum, exp_temp);
    end
  endtask

  task automatic test_random();
    logic [7:0] b[4];
    logic [7:0] s;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom_range(0, 255));
      s = 8'((int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256);
      if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
      test_frame("random", 1'($urandom_range(0, 1)), {b[0], b[1], b[2], b[3], s}, 99);
    end
  endtask

  task automatic test_rst_mid();
    pulse_start(1'b0);
    us_wait(100);
    total++;
    if (dhtio !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: got line=%b busy=%b, required line=0 busy=1", dhtio, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    exp_hum = 16'h0; exp_temp = 16'h0;
    total++;
    if ({dhtio, busy, debug, humidity, temperature, dht_valid, err_code} !== {1'b1, 1'b0, 4'(S_IDLE), 16'h0, 16'h0, 1'b0, 2'd0}) begin
      bad++; $display("FAIL rst_mid_post: got line=%b busy=%b debug=%0d hum=%h temp=%h valid=%b err=%0d, required released idle zeros",
                      dhtio, busy, debug, humidity, temperature, dht_valid, err_code);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

`ifdef DHT_AUTO_POLL_EN
  task automatic test_auto_poll();
    int low_cyc, cyc, gap;
    bit seen;
    pulse_start(1'b0);
    sensor_run(40'h0, 1'b0, 99, low_cyc);
    wait_done(2000, 1'b0, cyc, seen);
    gap = 0;
    while (dhtio !== 1'b0 && gap < 3000) begin @(negedge clk); gap++; end
    total++;
    if (gap < 1000 * CPU - 5 || gap > 1000 * CPU + 15) begin
      bad++; $display("FAIL auto_poll_gap: got %0d cycles, required about %0d", gap, 1000 * CPU);
    end
    wait_done(4000, 1'b0, cyc, seen);
  endtask
`endif

  initial begin
    test_reset();
`ifdef DHT_AUTO_POLL_EN
    test_auto_poll();
`else
    test_dht11();
    test_dht22();
    test_no_response();
    test_checksum();
    test_stall();
    test_busy_start();
    test_random();
    test_rst_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
